arbitro_botoes: RTL and testbench
=================================

# arbitro_botoes

Collects the one-cycle press pulses produced by the per-button synchronizers and turns them into a single ordered command stream for the main vending FSM. Each accepted press starts a per-button lockout window, which absorbs bounce and repeated presses. Pending presses are buffered one deep per button and granted round-robin through a valid/ready handshake. The block sits between the synchronizer bank and the control FSM.

## Interface
- N_BOTOES, 4, number of button inputs (2..8)
- LOCKOUT_CICLOS, 1000, lockout length in clock cycles after an accepted press (≥1)
- IDW, $clog2(N_BOTOES), width of the command id (derived, not overridden)
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- pulso  in  N_BOTOES  one-cycle press pulses; bit i comes from button i's synchronizer
- habilita  in  1  global enable; low means presses are ignored
- cmd_valid  out  1  command available
- cmd_id  out  IDW  index of the granted button; stable while cmd_valid=1 and cmd_ready=0
- cmd_ready  in  1  consumer accepts the command when cmd_valid=1 and cmd_ready=1
- bloqueado  out  N_BOTOES  bit i high while button i's lockout counter is non-zero
- descartado  out  1  one-cycle pulse when any press is dropped because of lockout or an already-pending press

## Operation
- Per-button state:
  - pendente[i] (1 bit)
  - lockout counter cnt[i], width $clog2(LOCKOUT_CICLOS+1)
- Acceptance:
  - Condition: pulso[i]=1, habilita=1, cnt[i]=0 and pendente[i]=0.
  - Effect: set pendente[i]; load cnt[i]=LOCKOUT_CICLOS.
  - Rejection: pulso[i]=1, habilita=1, and either cnt[i]≠0 or pendente[i]=1. The press is dropped and descartado=1 for one cycle; multiple simultaneous drops still give a single pulse.
- Counters:
  - cnt[i] decrements by 1 each cycle while non-zero, saturating at 0. It does not depend on habilita.
- Output slot: one register pair (cmd_valid, cmd_id).
  - The slot is free when cmd_valid=0 or (cmd_valid=1 and cmd_ready=1).
  - When the slot is free and any pendente bit is set, the round-robin winner is loaded into the slot, cmd_valid goes to 1, and that pendente bit clears on the same edge.
- Round-robin:
  - Pointer ptr starts at 0 after reset.
  - Search order is ptr, ptr+1, …, wrapping modulo N_BOTOES.
  - After granting button g, ptr becomes (g+1) mod N_BOTOES.
- habilita=0:
  - All pendente bits clear and new pulses are ignored; descartado stays 0.
  - A command already in the slot stays valid until it is handshaken. It is never withdrawn.
- Handshake rules:
  - cmd_valid never drops without cmd_ready=1, except on RESET.
  - cmd_id never changes while it is waiting to be accepted.
- Simultaneous events:
  - A pulse on button i during the cycle where pendente[i] is granted is impossible, because cnt[i] is still non-zero (LOCKOUT_CICLOS≥1).
  - Pulses on several buttons in the same cycle are all accepted independently.

## Timing
- Reset values, in effect the cycle after RESET is sampled high:
  - cmd_valid=0, cmd_id=0, descartado=0
  - bloqueado=0, every pendente=0, every cnt=0, ptr=0
- RESET mid-handshake discards the command with no handshake required.
- Latency: with pulso[i]=1 in cycle t and the slot empty, pendente[i]=1 in t+1 and cmd_valid=1 with cmd_id=i in t+2.
- Throughput: one command per cycle when cmd_ready is held at 1; back-to-back grants have no bubble.
- bloqueado[i] rises in cycle t+1 and stays high for exactly LOCKOUT_CICLOS cycles.
- descartado is registered: a drop sampled in cycle t produces the pulse in t+1.

## Structure
- Package arbitro_botoes_pkg holds:
  - default constants: N_BOTOES_PADRAO=4, LOCKOUT_PADRAO=1000
  - button id constants: BOTAO_CONFIRMA=0, BOTAO_CANCELA=1, BOTAO_PROXIMO=2, BOTAO_ANTERIOR=3
- One sub-module, contador_bloqueio (load, decrement, non-zero flag), instantiated N_BOTOES times.
- Pending bits, round-robin pick, and the output slot stay in the top module.

## Test plan
- Reset and single press (LOCKOUT_CICLOS=8): pulso=0001 in cycle 5 -> cmd_valid=1, cmd_id=0 in cycle 7; with cmd_ready=1 the command is accepted; bloqueado[0] is high in cycles 6–13.
- Bounce: pulso[2] high in cycles 10, 12 and 15, LOCKOUT_CICLOS=8 -> exactly one command with id=2; descartado pulses in cycles 13 and 16.
- Fairness: pulso=1111 in one cycle, cmd_ready=1 -> ids 0,1,2,3 on consecutive cycles. A second burst after lockout, starting with ptr=0 -> the same order again.
- Backpressure: cmd_ready=0 for 20 cycles with pulso[1] and pulso[3] pending -> cmd_id=1 stays constant. Release cmd_ready -> id 1 then id 3, with no duplicates.
- habilita dropped while slot holds id=3 and pendente[0]=1 -> id 3 is still delivered, id 0 is never issued, and descartado stays 0.
- RESET asserted while cmd_valid=1 -> the next cycle shows cmd_valid=0 and bloqueado=0; a new press is accepted immediately after RESET deasserts.

Source files
------------

// File: rtl/arbitro_botoes_pkg.sv
// rtl/arbitro_botoes_pkg.sv - shared constants for the button arbiter
// Holds the default sizing, the button id constants used by the
// vending FSM, and the round-robin wrap helper.
package arbitro_botoes_pkg;

  localparam int N_BOTOES_PADRAO = 4;
  localparam int LOCKOUT_PADRAO  = 1000;

  localparam int BOTAO_CONFIRMA = 0;
  localparam int BOTAO_CANCELA  = 1;
  localparam int BOTAO_PROXIMO  = 2;
  localparam int BOTAO_ANTERIOR = 3;

  // Next index after idx, wrapping to 0 at n (n need not be a power of two).
  function automatic int proximo_indice(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arbitro_botoes_contador.sv
// rtl/arbitro_botoes_contador.sv - per-button lockout down-counter
// Ports:
//   CLOCK, RESET : clock, synchronous active-high reset
//   carrega      : load the counter with LOCKOUT_CICLOS
//   ativo        : high while the counter is non-zero
module contador_bloqueio #(
  parameter int LOCKOUT_CICLOS = 1000,
  localparam int CW = $clog2(LOCKOUT_CICLOS + 1)
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic carrega,
  output logic ativo
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (carrega) begin
      cnt <= CW'(LOCKOUT_CICLOS);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign ativo = (cnt != '0);

endmodule

// File: rtl/arbitro_botoes.sv
// rtl/arbitro_botoes.sv - press pulse arbiter with lockout and round-robin grant
// Ports:
//   CLOCK, RESET        : clock, synchronous active-high reset
//   pulso[N_BOTOES]     : one-cycle press pulses from the synchronizers
//   habilita            : global enable; low clears pending presses
//   cmd_valid/cmd_id    : output command slot (held until cmd_ready)
//   cmd_ready           : consumer accepts the slot contents
//   bloqueado[N_BOTOES] : per-button lockout active
//   descartado          : registered pulse when any press is dropped
module arbitro_botoes
  import arbitro_botoes_pkg::*;
#(
  parameter int N_BOTOES       = N_BOTOES_PADRAO,
  parameter int LOCKOUT_CICLOS = LOCKOUT_PADRAO,
  localparam int IDW = $clog2(N_BOTOES)
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [N_BOTOES-1:0] pulso,
  input  logic                habilita,
  output logic                cmd_valid,
  output logic [IDW-1:0]      cmd_id,
  input  logic                cmd_ready,
  output logic [N_BOTOES-1:0] bloqueado,
  output logic                descartado
);

  logic [N_BOTOES-1:0] pendente;
  logic [N_BOTOES-1:0] ativo;
  logic [N_BOTOES-1:0] aceita;
  logic [N_BOTOES-1:0] rejeita;
  logic [N_BOTOES-1:0] limpa;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      vencedor;
  logic                achou;
  logic                slot_livre;
  logic                concede;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_cnt
    contador_bloqueio #(
      .LOCKOUT_CICLOS(LOCKOUT_CICLOS)
    ) u_cnt (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .carrega(aceita[g]),
      .ativo  (ativo[g])
    );
  end

  assign bloqueado = ativo;

  // A press is accepted only when the button is idle; otherwise it is a drop.
  always_comb begin
    aceita  = '0;
    rejeita = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (pulso[i] && habilita) begin
        if (ativo[i] || pendente[i]) rejeita[i] = 1'b1;
        else                         aceita[i]  = 1'b1;
      end
    end
  end

  // First pending button at or after ptr, wrapping around.
  always_comb begin
    int idx;
    vencedor = '0;
    achou    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_BOTOES; k++) begin
      idx = (int'(ptr) + k) % N_BOTOES;
      if (!achou && pendente[idx]) begin
        achou    = 1'b1;
        vencedor = IDW'(idx);
      end
    end
  end

  // Grants stop while disabled so a cleared pending press is never issued.
  assign slot_livre = !cmd_valid || cmd_ready;
  assign concede    = slot_livre && habilita && achou;

  always_comb begin
    limpa = '0;
    if (concede) limpa[vencedor] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pendente   <= '0;
      ptr        <= '0;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      descartado <= 1'b0;
    end else begin
      descartado <= |rejeita;
      if (!habilita) pendente <= '0;
      else           pendente <= (pendente | aceita) & ~limpa;
      if (concede) begin
        cmd_valid <= 1'b1;
        cmd_id    <= vencedor;
        ptr       <= IDW'(proximo_indice(int'(vencedor), N_BOTOES));
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_botoes.sv
// tb/tb_arbitro_botoes.sv - self-checking bench for arbitro_botoes
module tb_arbitro_botoes;
  import arbitro_botoes_pkg::*;

  localparam int N = 4;
  localparam int L = 8;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic [N-1:0] pulso;
  logic         habilita;
  logic         cmd_valid;
  logic [1:0]   cmd_id;
  logic         cmd_ready;
  logic [N-1:0] bloqueado;
  logic         descartado;

  arbitro_botoes #(.N_BOTOES(N), .LOCKOUT_CICLOS(L)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .pulso     (pulso),
    .habilita  (habilita),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_ready (cmd_ready),
    .bloqueado (bloqueado),
    .descartado(descartado)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_err = 0;

  bit m_pend[N];
  int m_lock[N];
  bit m_valid;
  int m_id;
  int m_ptr;
  bit m_desc;
  bit m_rst;

  int entregues[$];
  int hi0, nd, desc_mask;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vec++;
    assert (obs === esp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [N-1:0] m_bloq();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (m_lock[i] > 0);
    return b;
  endfunction

  function automatic int em(input int k);
    return (k < entregues.size()) ? entregues[k] : -1;
  endfunction

  // Reference behaviour for one clock edge, from the block's rules.
  task automatic modelo();
    int acc[N];
    bit drop;
    int g;
    int idx;
    m_rst = RESET;
    if (RESET) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_lock[i] = 0; end
      m_valid = 0; m_id = 0; m_ptr = 0; m_desc = 0;
      return;
    end
    drop = 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = 0;
      if (pulso[i] && habilita) begin
        if (m_lock[i] > 0 || m_pend[i]) drop = 1;
        else acc[i] = 1;
      end
    end
    g = -1;
    if ((!m_valid || cmd_ready) && habilita)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    for (int i = 0; i < N; i++) begin
      m_lock[i] = acc[i] ? L : (m_lock[i] > 0 ? m_lock[i] - 1 : 0);
      m_pend[i] = habilita && (m_pend[i] || acc[i] != 0) && (i != g);
    end
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_ptr = (g + 1) % N;
    end else if (m_valid && cmd_ready) begin
      m_valid = 0;
    end
    m_desc = drop;
  endtask

  task automatic tick();
    if (cmd_valid === 1'b1 && cmd_ready && !RESET) entregues.push_back(int'(cmd_id));
    @(posedge CLOCK);
    modelo();
    #1;
    verifica("cmd_valid", cmd_valid, m_valid);
    if (m_valid || m_rst) verifica("cmd_id", cmd_id, m_id);
    verifica("bloqueado", bloqueado, m_bloq());
    verifica("descartado", descartado, m_desc);
  endtask

  initial begin
    RESET = 1; pulso = '0; habilita = 1; cmd_ready = 0;

    // Reset and single press
    tick(); tick();
    verifica("rst_valid", cmd_valid, 0);
    verifica("rst_id", cmd_id, 0);
    verifica("rst_bloq", bloqueado, 0);
    verifica("rst_desc", descartado, 0);
    RESET = 0; tick();
    entregues.delete(); hi0 = 0;
    pulso = 4'b0001; tick(); pulso = '0;
    if (bloqueado[0]) hi0++;
    verifica("t1_no_valid_yet", cmd_valid, 0);
    tick(); if (bloqueado[0]) hi0++;
    verifica("t1_valid", cmd_valid, 1);
    verifica("t1_id", cmd_id, BOTAO_CONFIRMA);
    cmd_ready = 1;
    repeat (12) begin tick(); if (bloqueado[0]) hi0++; end
    verifica("t1_lock_len", hi0, L);
    verifica("t1_count", entregues.size(), 1);

    // Bounce on button 2
    entregues.delete(); nd = 0; desc_mask = 0;
    for (int c = 0; c < 14; c++) begin
      pulso = (c == 0 || c == 2 || c == 5) ? 4'b0100 : 4'b0000;
      tick();
      if (descartado) begin nd++; desc_mask |= (1 << c); end
    end
    pulso = '0;
    verifica("bounce_drops", nd, 2);
    verifica("bounce_desc_cycles", desc_mask, (1 << 2) | (1 << 5));
    verifica("bounce_cmds", entregues.size(), 1);
    verifica("bounce_id", em(0), BOTAO_PROXIMO);

    // Fairness: two bursts from ptr=0
    RESET = 1; tick(); RESET = 0;
    for (int b = 0; b < 2; b++) begin
      entregues.delete();
      pulso = 4'b1111; tick(); pulso = '0;
      for (int k = 0; k < 4; k++) begin
        tick();
        verifica("fair_valid", cmd_valid, 1);
        verifica("fair_id", cmd_id, k);
      end
      repeat (10) tick();
      verifica("fair_count", entregues.size(), 4);
    end

    // Backpressure
    cmd_ready = 0; entregues.delete();
    pulso = 4'b1010; tick(); pulso = '0; tick();
    repeat (20) begin
      tick();
      verifica("bp_valid", cmd_valid, 1);
      verifica("bp_id", cmd_id, BOTAO_CANCELA);
    end
    cmd_ready = 1;
    repeat (4) tick();
    verifica("bp_count", entregues.size(), 2);
    verifica("bp_first", em(0), 1);
    verifica("bp_second", em(1), 3);

    // habilita dropped with id 3 in the slot and button 0 pending
    cmd_ready = 0; entregues.delete(); nd = 0;
    pulso = 4'b1000; tick(); pulso = '0; tick();
    pulso = 4'b0001; tick(); pulso = '0;
    verifica("hab_slot_id", cmd_id, BOTAO_ANTERIOR);
    habilita = 0;
    pulso = 4'b0001; tick(); pulso = '0; if (descartado) nd++;
    repeat (3) begin tick(); if (descartado) nd++; end
    cmd_ready = 1;
    repeat (3) begin tick(); if (descartado) nd++; end
    habilita = 1;
    repeat (4) begin tick(); if (descartado) nd++; end
    verifica("hab_desc", nd, 0);
    verifica("hab_count", entregues.size(), 1);
    verifica("hab_id", em(0), 3);

    // Reset mid-handshake
    repeat (10) tick();
    cmd_ready = 0;
    pulso = 4'b0100; tick(); pulso = '0; tick();
    verifica("rm_valid", cmd_valid, 1);
    RESET = 1; tick();
    verifica("rm_valid_clr", cmd_valid, 0);
    verifica("rm_bloq_clr", bloqueado, 0);
    RESET = 0; pulso = 4'b0001; tick(); pulso = '0;
    verifica("rm_bloq_new", bloqueado, 4'b0001);
    tick();
    verifica("rm_new_valid", cmd_valid, 1);
    verifica("rm_new_id", cmd_id, 0);
    cmd_ready = 1; tick();

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      RESET     = ($urandom_range(0, 99) == 0);
      habilita  = ($urandom_range(0, 9) != 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) pulso[i] = ($urandom_range(0, 5) == 0);
      tick();
    end
    RESET = 0; pulso = '0; habilita = 1; cmd_ready = 1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
